// File: rtl/tone_burst_gen.sv
// Square-wave tone / beep-sequence generator feeding the serial DAC sample input.
// Latency: start sampled on one edge, first high sample registered on that same edge (visible next cycle).
// Backpressure: none; start ignored while busy, stop aborts immediately without a done pulse.
module tone_burst_gen #(
    parameter int DATA_W = 12,
    parameter int HP_W   = 20,
    parameter int LEN_W  = 32,
    parameter int CNT_W  = 4
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [HP_W-1:0]   half_period,
    input  logic [LEN_W-1:0]  tone_len,
    input  logic [LEN_W-1:0]  gap_len,
    input  logic [CNT_W-1:0]  beep_count,
    input  logic [DATA_W-1:0] amplitude,
    output logic [DATA_W-1:0] audio_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  beeps_left
);

    typedef enum logic [1:0] {S_IDLE, S_TONE, S_GAP} state_t;

    state_t              r_state;
    logic [HP_W-1:0]     r_hp;
    logic [LEN_W-1:0]    r_tone_len;
    logic [LEN_W-1:0]    r_gap_len;
    logic [DATA_W-1:0]   r_amp;
    logic                r_cont;
    logic [HP_W-1:0]     r_half_cnt;
    logic [LEN_W-1:0]    r_tone_cnt;
    logic [LEN_W-1:0]    r_gap_cnt;
    logic                r_phase;
    logic [DATA_W-1:0]   r_audio;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    r_beeps_left;

    // Zero pitch and zero burst length are clamped to one cycle at latch time.
    logic [HP_W-1:0]     w_hp_eff;
    logic [LEN_W-1:0]    w_tl_eff;
    assign w_hp_eff = (half_period == '0) ? HP_W'(1) : half_period;
    assign w_tl_eff = (tone_len == '0) ? LEN_W'(1) : tone_len;

    assign audio_out  = r_audio;
    assign busy       = r_busy;
    assign done       = r_done;
    assign beeps_left = r_beeps_left;

    // Sequencer: shadow config, square-wave phase, burst/gap counters and registered outputs.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_hp         <= '0;
            r_tone_len   <= '0;
            r_gap_len    <= '0;
            r_amp        <= '0;
            r_cont       <= 1'b0;
            r_half_cnt   <= '0;
            r_tone_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_phase      <= 1'b0;
            r_audio      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_beeps_left <= '0;
        end else begin
            r_done <= 1'b0;
            if (stop) begin
                r_state      <= S_IDLE;
                r_phase      <= 1'b0;
                r_audio      <= '0;
                r_busy       <= 1'b0;
                r_beeps_left <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_audio      <= '0;
                        r_busy       <= 1'b0;
                        r_beeps_left <= '0;
                        if (start) begin
                            r_hp         <= w_hp_eff;
                            r_tone_len   <= w_tl_eff;
                            r_gap_len    <= gap_len;
                            r_amp        <= amplitude;
                            r_cont       <= (beep_count == '0);
                            r_state      <= S_TONE;
                            r_phase      <= 1'b1;
                            r_half_cnt   <= w_hp_eff;
                            r_tone_cnt   <= w_tl_eff;
                            r_audio      <= amplitude;
                            r_busy       <= 1'b1;
                            r_beeps_left <= beep_count;
                        end
                    end
                    S_TONE: begin
                        if (r_tone_cnt == LEN_W'(1)) begin
                            if (!r_cont && r_beeps_left == CNT_W'(1)) begin
                                r_state      <= S_IDLE;
                                r_done       <= 1'b1;
                                r_audio      <= '0;
                                r_busy       <= 1'b0;
                                r_beeps_left <= '0;
                                r_phase      <= 1'b0;
                            end else begin
                                if (!r_cont) begin
                                    r_beeps_left <= r_beeps_left - CNT_W'(1);
                                end
                                if (r_gap_len != '0) begin
                                    r_state   <= S_GAP;
                                    r_gap_cnt <= r_gap_len;
                                    r_audio   <= '0;
                                    r_phase   <= 1'b0;
                                end else begin
                                    // Every burst restarts high with a full half-period.
                                    r_phase    <= 1'b1;
                                    r_half_cnt <= r_hp;
                                    r_tone_cnt <= r_tone_len;
                                    r_audio    <= r_amp;
                                end
                            end
                        end else begin
                            r_tone_cnt <= r_tone_cnt - LEN_W'(1);
                            if (r_half_cnt == HP_W'(1)) begin
                                r_half_cnt <= r_hp;
                                r_phase    <= ~r_phase;
                                r_audio    <= r_phase ? '0 : r_amp;
                            end else begin
                                r_half_cnt <= r_half_cnt - HP_W'(1);
                                r_audio    <= r_phase ? r_amp : '0;
                            end
                        end
                    end
                    S_GAP: begin
                        r_audio <= '0;
                        if (r_gap_cnt == LEN_W'(1)) begin
                            r_state    <= S_TONE;
                            r_phase    <= 1'b1;
                            r_half_cnt <= r_hp;
                            r_tone_cnt <= r_tone_len;
                            r_audio    <= r_amp;
                        end else begin
                            r_gap_cnt <= r_gap_cnt - LEN_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_audio <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
